// File: rtl/frame_scheduler_if.sv
// frame_scheduler_if: command/completion bus between the frame scheduler and the ROM-to-RAM copy engine
interface frame_scheduler_if #(
  parameter int ADR_WIDTH = 16,
  parameter int OUT_WIDTH = 8
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [ADR_WIDTH-1:0] cmd_src;
  logic [ADR_WIDTH-1:0] cmd_dst;
  logic [ADR_WIDTH-1:0] cmd_limit;
  logic [OUT_WIDTH-1:0] cmd_x;
  logic [OUT_WIDTH-1:0] cmd_y;
  logic                 cmd_term;
  logic                 done;
  logic [ADR_WIDTH-1:0] done_len;
  modport master (
    output cmd_valid, cmd_src, cmd_dst, cmd_limit, cmd_x, cmd_y, cmd_term,
    input  cmd_ready, done, done_len
  );
  modport slave (
    input  cmd_valid, cmd_src, cmd_dst, cmd_limit, cmd_x, cmd_y, cmd_term,
    output cmd_ready, done, done_len
  );
endinterface

// File: rtl/frame_scheduler.sv
// frame_scheduler: builds each display frame in point RAM via copy commands, appends an end-marker, then hands off to the display
module frame_scheduler #(
  parameter int ADR_WIDTH    = 16,
  parameter int OUT_WIDTH    = 8,
  parameter int N_OBJ        = 8,
  parameter int RAM_DEPTH    = 1000,
  parameter int HALT_TIMEOUT = 40_000_000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_OBJ-1:0]           obj_valid,
  input  logic [N_OBJ*ADR_WIDTH-1:0] obj_adr,
  input  logic [N_OBJ*OUT_WIDTH-1:0] obj_x,
  input  logic [N_OBJ*OUT_WIDTH-1:0] obj_y,
  frame_scheduler_if.master          eng,
  output logic                       go,
  input  logic                       halt,
  output logic [ADR_WIDTH-1:0]       frame_len,
  output logic                       overflow,
  output logic                       halt_timeout
);
  localparam int IW = N_OBJ > 1 ? $clog2(N_OBJ) : 1;
  localparam logic [ADR_WIDTH-1:0] LAST = ADR_WIDTH'(RAM_DEPTH - 1);
  localparam logic [31:0] HT_LAST = 32'(HALT_TIMEOUT - 1);
  typedef enum logic [2:0] {IDLE, SCAN, ISSUE, WAIT_DONE, TERM, WAIT_TERM, WAIT_HALT} state_t;
  state_t               state_q, state_d;
  logic [N_OBJ-1:0]     valid_q, valid_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [ADR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADR_WIDTH-1:0] frame_len_q, frame_len_d;
  logic                 overflow_q, overflow_d;
  logic [31:0]          cnt_q, cnt_d;
  logic                 go_q, go_d;
  logic                 halt_timeout_q, halt_timeout_d;
  logic                 cmd_valid_q, cmd_valid_d;
  logic                 cmd_term_q, cmd_term_d;
  logic [ADR_WIDTH-1:0] cmd_src_q, cmd_src_d;
  logic [ADR_WIDTH-1:0] cmd_dst_q, cmd_dst_d;
  logic [ADR_WIDTH-1:0] cmd_limit_q, cmd_limit_d;
  logic [OUT_WIDTH-1:0] cmd_x_q, cmd_x_d;
  logic [OUT_WIDTH-1:0] cmd_y_q, cmd_y_d;
  logic [ADR_WIDTH-1:0] sel_adr, step;
  logic [OUT_WIDTH-1:0] sel_x, sel_y;
  logic                 start, issue, term, last_idx;
  assign last_idx = idx_q == IW'(N_OBJ - 1);
  // the limit caps every copy, so wr_ptr can never pass RAM_DEPTH-1
  assign step = eng.done_len < cmd_limit_q ? eng.done_len : cmd_limit_q;
  always_comb begin
    sel_adr = '0;
    sel_x   = '0;
    sel_y   = '0;
    for (int i = 0; i < N_OBJ; i++)
      if (idx_q == IW'(i)) begin
        sel_adr = obj_adr[i*ADR_WIDTH +: ADR_WIDTH];
        sel_x   = obj_x[i*OUT_WIDTH +: OUT_WIDTH];
        sel_y   = obj_y[i*OUT_WIDTH +: OUT_WIDTH];
      end
  end
  always_comb begin
    state_d        = state_q;
    valid_d        = valid_q;
    idx_d          = idx_q;
    wr_ptr_d       = wr_ptr_q;
    frame_len_d    = frame_len_q;
    overflow_d     = overflow_q;
    cnt_d          = '0;
    go_d           = go_q;
    halt_timeout_d = 1'b0;
    cmd_valid_d    = cmd_valid_q;
    cmd_term_d     = cmd_term_q;
    cmd_src_d      = cmd_src_q;
    cmd_dst_d      = cmd_dst_q;
    cmd_limit_d    = cmd_limit_q;
    cmd_x_d        = cmd_x_q;
    cmd_y_d        = cmd_y_q;
    start          = 1'b0;
    issue          = 1'b0;
    term           = 1'b0;
    case (state_q)
      IDLE: start = 1'b1;
      SCAN:
        if (valid_q[idx_q]) begin
          issue      = wr_ptr_q < LAST;
          term       = !issue;
          overflow_d = overflow_q | !issue;
        end else if (last_idx) term = 1'b1;
        else idx_d = idx_q + IW'(1);
      ISSUE:
        if (eng.cmd_ready) begin
          cmd_valid_d = 1'b0;
          state_d     = WAIT_DONE;
        end
      WAIT_DONE:
        if (eng.done) begin
          wr_ptr_d = wr_ptr_q + step;
          term     = last_idx;
          idx_d    = last_idx ? idx_q : idx_q + IW'(1);
          state_d  = SCAN;
        end
      TERM:
        if (eng.cmd_ready) begin
          cmd_valid_d = 1'b0;
          state_d     = WAIT_TERM;
        end
      WAIT_TERM:
        if (eng.done) begin
          frame_len_d = wr_ptr_q + ADR_WIDTH'(1);
          go_d        = 1'b1;
          state_d     = WAIT_HALT;
        end
      WAIT_HALT: begin
        cnt_d = cnt_q + 32'd1;
        if (halt) begin
          go_d  = 1'b0;
          start = 1'b1;
        end else if (HALT_TIMEOUT != 0 && cnt_q == HT_LAST) begin
          go_d           = 1'b0;
          halt_timeout_d = 1'b1;
          start          = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // frame start: take the object snapshot that the whole frame is built from
    if (start) begin
      state_d    = SCAN;
      valid_d    = obj_valid;
      idx_d      = '0;
      wr_ptr_d   = '0;
      overflow_d = 1'b0;
      cnt_d      = '0;
    end
    if (issue) begin
      state_d     = ISSUE;
      cmd_valid_d = 1'b1;
      cmd_term_d  = 1'b0;
      cmd_src_d   = sel_adr;
      cmd_x_d     = sel_x;
      cmd_y_d     = sel_y;
      cmd_dst_d   = wr_ptr_q;
      cmd_limit_d = LAST - wr_ptr_q;
    end
    if (term) begin
      state_d     = TERM;
      cmd_valid_d = 1'b1;
      cmd_term_d  = 1'b1;
      cmd_src_d   = '0;
      cmd_x_d     = '0;
      cmd_y_d     = '0;
      cmd_dst_d   = wr_ptr_d;
      cmd_limit_d = ADR_WIDTH'(1);
    end
  end
  always_ff @(posedge clk)
    if (!rst) begin
      state_q        <= IDLE;
      valid_q        <= '0;
      idx_q          <= '0;
      wr_ptr_q       <= '0;
      frame_len_q    <= '0;
      overflow_q     <= 1'b0;
      cnt_q          <= '0;
      go_q           <= 1'b0;
      halt_timeout_q <= 1'b0;
      cmd_valid_q    <= 1'b0;
      cmd_term_q     <= 1'b0;
      cmd_src_q      <= '0;
      cmd_dst_q      <= '0;
      cmd_limit_q    <= '0;
      cmd_x_q        <= '0;
      cmd_y_q        <= '0;
    end else begin
      state_q        <= state_d;
      valid_q        <= valid_d;
      idx_q          <= idx_d;
      wr_ptr_q       <= wr_ptr_d;
      frame_len_q    <= frame_len_d;
      overflow_q     <= overflow_d;
      cnt_q          <= cnt_d;
      go_q           <= go_d;
      halt_timeout_q <= halt_timeout_d;
      cmd_valid_q    <= cmd_valid_d;
      cmd_term_q     <= cmd_term_d;
      cmd_src_q      <= cmd_src_d;
      cmd_dst_q      <= cmd_dst_d;
      cmd_limit_q    <= cmd_limit_d;
      cmd_x_q        <= cmd_x_d;
      cmd_y_q        <= cmd_y_d;
    end
  assign eng.cmd_valid = cmd_valid_q;
  assign eng.cmd_term  = cmd_term_q;
  assign eng.cmd_src   = cmd_src_q;
  assign eng.cmd_dst   = cmd_dst_q;
  assign eng.cmd_limit = cmd_limit_q;
  assign eng.cmd_x     = cmd_x_q;
  assign eng.cmd_y     = cmd_y_q;
  assign go            = go_q;
  assign frame_len     = frame_len_q;
  assign overflow      = overflow_q;
  assign halt_timeout  = halt_timeout_q;
endmodule

// File: tb/tb_frame_scheduler.sv
// tb_frame_scheduler: randomized frames against a frame-level reference model of the scheduler
module tb_frame_scheduler;
  localparam int AW = 16, OW = 8, N = 8, D = 40, TO = 100, NF = 24;
  typedef struct {
    logic [AW-1:0] src, dst, lim, len;
    logic [OW-1:0] x, y;
    logic          term;
  } cmd_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [N-1:0] obj_valid;
  logic [N*AW-1:0] obj_adr;
  logic [N*OW-1:0] obj_x, obj_y;
  logic go, halt, overflow, halt_timeout;
  logic [AW-1:0] frame_len;
  cmd_t exp_q[$];
  logic [AW-1:0] exp_flen;
  logic exp_ovf;
  int len_tab[N];
  int total = 0, bad = 0;
  bit abort = 0;
  int nxt_stall, nxt_to, nxt_h, cur_stall, cur_to, cur_h;
  frame_scheduler_if #(.ADR_WIDTH(AW), .OUT_WIDTH(OW)) bus ();
  frame_scheduler #(.ADR_WIDTH(AW), .OUT_WIDTH(OW), .N_OBJ(N), .RAM_DEPTH(D), .HALT_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .obj_valid(obj_valid), .obj_adr(obj_adr), .obj_x(obj_x), .obj_y(obj_y),
    .eng(bus), .go(go), .halt(halt), .frame_len(frame_len), .overflow(overflow), .halt_timeout(halt_timeout)
  );
  always #5 clk = ~clk;
  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // frame-level model: lay valid sprites end to end, cap each at the space left, stop when only the marker slot remains
  task automatic setup(input logic [N-1:0] v, input int stall, input int to_mode, input int h);
    int ptr, lim, l;
    cmd_t c;
    exp_q.delete();
    exp_ovf = 1'b0;
    ptr = 0;
    obj_valid = v;
    for (int i = 0; i < N; i++) begin
      obj_adr[i*AW +: AW] = AW'($urandom);
      obj_x[i*OW +: OW]   = OW'($urandom);
      obj_y[i*OW +: OW]   = OW'($urandom);
    end
    for (int i = 0; i < N; i++)
      if (v[i]) begin
        if (ptr == D - 1) begin
          exp_ovf = 1'b1;
          break;
        end
        lim = D - 1 - ptr;
        l = len_tab[i] >= 0 ? len_tab[i] : int'($urandom_range(0, 20));
        c.src = obj_adr[i*AW +: AW];
        c.x = obj_x[i*OW +: OW];
        c.y = obj_y[i*OW +: OW];
        c.dst = AW'(ptr);
        c.lim = AW'(lim);
        c.len = AW'(l);
        c.term = 1'b0;
        exp_q.push_back(c);
        ptr += l < lim ? l : lim;
      end
    c.src = '0;
    c.x = '0;
    c.y = '0;
    c.dst = AW'(ptr);
    c.lim = AW'(1);
    c.len = AW'($urandom);
    c.term = 1'b1;
    exp_q.push_back(c);
    exp_flen = AW'(ptr + 1);
    nxt_stall = stall;
    nxt_to = to_mode;
    nxt_h = h;
    for (int i = 0; i < N; i++) len_tab[i] = -1;
  endtask
  task automatic setup_frame(input int f);
    logic [N-1:0] v;
    v = N'($urandom);
    case (f)
      0, 1: setup('0, -1, 0, 5);
      2: begin
        len_tab[0] = 10;
        len_tab[2] = 7;
        setup(8'b0000_0101, -1, 0, int'($urandom_range(0, 10)));
      end
      3: setup(v | N'(1), 20, 0, 3);
      4: begin
        len_tab[1] = 30;
        len_tab[2] = 30;
        len_tab[4] = 30;
        setup(8'b0001_0110, -1, 0, 2);
      end
      5: setup(v, -1, 1, 0);
      NF: setup('1, -1, 0, 1);
      default: setup(v, -1, int'($urandom_range(0, 5) == 0), int'($urandom_range(0, 10)));
    endcase
  endtask
  task automatic run_cmds();
    cmd_t c;
    int n, st, dly;
    while (exp_q.size() > 0 && !abort) begin
      c = exp_q.pop_front();
      n = 0;
      while (bus.cmd_valid !== 1'b1 && n < 100) begin
        @(negedge clk);
        n++;
      end
      check("cmd_wait", bus.cmd_valid, 1);
      if (bus.cmd_valid !== 1'b1) begin
        abort = 1;
        return;
      end
      st = cur_stall >= 0 ? cur_stall : int'($urandom_range(0, 4));
      for (int k = 0; k <= st; k++) begin
        check("cmd_valid", bus.cmd_valid, 1);
        check("cmd_src", bus.cmd_src, c.src);
        check("cmd_dst", bus.cmd_dst, c.dst);
        check("cmd_limit", bus.cmd_limit, c.lim);
        check("cmd_x", bus.cmd_x, c.x);
        check("cmd_y", bus.cmd_y, c.y);
        check("cmd_term", bus.cmd_term, c.term);
        bus.cmd_ready = k == st;
        bus.done = $urandom_range(0, 3) == 0;
        bus.done_len = AW'($urandom);
        halt = k < st && $urandom_range(0, 3) == 0;
        @(negedge clk);
      end
      check("cmd_drop", bus.cmd_valid, 0);
      bus.done = 1'b0;
      halt = 1'b0;
      dly = $urandom_range(0, 3);
      repeat (dly) begin
        bus.cmd_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        check("cmd_idle", bus.cmd_valid, 0);
      end
      bus.cmd_ready = 1'b0;
      bus.done = 1'b1;
      bus.done_len = c.len;
      @(negedge clk);
      bus.done = 1'b0;
      bus.done_len = AW'($urandom);
      halt = !c.term && $urandom_range(0, 1) == 1;
    end
  endtask
  task automatic check_frame_end();
    check("go_rise", go, 1);
    check("frame_len", frame_len, exp_flen);
    check("overflow", overflow, exp_ovf);
  endtask
  task automatic check_all_zero();
    check("rst_cmd_valid", bus.cmd_valid, 0);
    check("rst_cmd_src", bus.cmd_src, 0);
    check("rst_cmd_dst", bus.cmd_dst, 0);
    check("rst_cmd_limit", bus.cmd_limit, 0);
    check("rst_cmd_xy", {bus.cmd_x, bus.cmd_y}, 0);
    check("rst_cmd_term", bus.cmd_term, 0);
    check("rst_go", go, 0);
    check("rst_frame_len", frame_len, 0);
    check("rst_overflow", overflow, 0);
    check("rst_halt_timeout", halt_timeout, 0);
  endtask
  initial begin
    int n, tc;
    halt = 1'b0;
    bus.cmd_ready = 1'b0;
    bus.done = 1'b0;
    bus.done_len = '0;
    obj_valid = '0;
    obj_adr = '0;
    obj_x = '0;
    obj_y = '0;
    for (int i = 0; i < N; i++) len_tab[i] = -1;
    repeat (3) @(negedge clk);
    check_all_zero();
    setup_frame(0);
    rst = 1'b1;
    for (int f = 0; f < NF && !abort; f++) begin
      cur_stall = nxt_stall;
      cur_to = nxt_to;
      cur_h = nxt_h;
      run_cmds();
      if (abort) break;
      check_frame_end();
      setup_frame(f + 1);
      if (cur_to != 0) begin
        n = 0;
        tc = 0;
        while (go === 1'b1 && n < 200) begin
          n++;
          tc += int'(halt_timeout);
          @(negedge clk);
        end
        check("go_cycles", n, TO);
        tc += int'(halt_timeout);
        obj_valid = N'($urandom);
        @(negedge clk);
        tc += int'(halt_timeout);
        check("timeout_pulses", tc, 1);
      end else begin
        for (int i = 0; i <= cur_h; i++) begin
          check("go_hold", go, 1);
          check("no_timeout", halt_timeout, 0);
          halt = i == cur_h;
          @(negedge clk);
        end
        halt = 1'b0;
        check("go_fall", go, 0);
        obj_valid = N'($urandom);
      end
    end
    if (!abort) begin
      n = 0;
      while (bus.cmd_valid !== 1'b1 && n < 100) begin
        @(negedge clk);
        n++;
      end
      check("rst_cmd_wait", bus.cmd_valid, 1);
      bus.cmd_ready = 1'b1;
      @(negedge clk);
      bus.cmd_ready = 1'b0;
      check("rst_pre_drop", bus.cmd_valid, 0);
      rst = 1'b0;
      @(negedge clk);
      check_all_zero();
      setup(N'($urandom) | N'(1), -1, 0, 1);
      cur_stall = nxt_stall;
      rst = 1'b1;
      run_cmds();
      if (!abort) check_frame_end();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
